frame_scheduler: RTL and testbench

Frame sequencer for the asteroid game: a programmable-rate prescaler produces one frame tick per period on the 50 MHz input clock. Each tick drives a fixed handshake sequence through the game engines: move, then collision check, then an optional spawn. Frame rate rises with level. The block sits between the top-level game control (run/pause/level) and the movement, collision and spawner engines, and replaces free-running dividers as the single source of game timing.

---
 rtl/game_timing_pkg.sv | 38 +++
 rtl/frame_scheduler_if.sv | 30 +++
 rtl/rate_prescaler.sv | 33 +++
 rtl/frame_scheduler.sv | 121 ++++++++++++
 tb/tb_frame_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the asteroid game: frame FSM states, default
// divider constants and the level-to-period clamp rule.
package game_timing_pkg;

    localparam int unsigned DIV_W       = 32;
    localparam int unsigned LEVEL_W     = 3;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam logic [DIV_W-1:0] BASE_DIV_DEF    = 32'd5000000;
    localparam logic [DIV_W-1:0] STEP_DIV_DEF    = 32'd500000;
    localparam logic [DIV_W-1:0] MIN_DIV_DEF     = 32'd1000000;
    localparam int unsigned      SPAWN_EVERY_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        COLL  = 2'd2,
        SPAWN = 2'd3
    } frame_state_e;

    // Period shrinks by step_div per level; underflow or anything below min_div clamps to min_div.
    function automatic logic [DIV_W-1:0] calc_period(
        input logic [LEVEL_W-1:0] lvl,
        input logic [DIV_W-1:0]   base_div,
        input logic [DIV_W-1:0]   step_div,
        input logic [DIV_W-1:0]   min_div
    );
        logic [DIV_W-1:0] reduction;
        logic [DIV_W-1:0] diff;
        reduction = DIV_W'(lvl) * step_div;
        diff      = base_div - reduction;
        if ((reduction > base_div) || (diff < min_div)) begin
            return min_div;
        end
        return diff;
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Request/done handshake bundle between the frame scheduler and the
// movement, collision and spawner engines.
interface frame_scheduler_if;

    logic move_req;
    logic move_done;
    logic coll_req;
    logic coll_done;
    logic spawn_req;
    logic spawn_done;

    modport master (
        output move_req,
        output coll_req,
        output spawn_req,
        input  move_done,
        input  coll_done,
        input  spawn_done
    );

    modport slave (
        input  move_req,
        input  coll_req,
        input  spawn_req,
        output move_done,
        output coll_done,
        output spawn_done
    );

endinterface

// File: rtl/rate_prescaler.sv
// Programmable-period prescaler: one tick every 'period' enabled cycles,
// frozen by pause and cleared while run is low.
module rate_prescaler
    import game_timing_pkg::*;
(
    input  logic             cin,
    input  logic             rst_n,
    input  logic             run,
    input  logic             pause,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    logic [DIV_W-1:0] count_q;
    logic             enable_c;

    assign enable_c = run && !pause;
    // Tick is combinational so the scheduler reacts on the terminal-count edge.
    assign tick     = enable_c && (count_q == (period - DIV_W'(1)));

    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (!run) begin
            count_q <= '0;
        end else if (tick) begin
            count_q <= '0;
        end else if (enable_c) begin
            count_q <= count_q + DIV_W'(1);
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Frame sequencer: each prescaler tick runs move -> collision -> optional spawn
// through the engine handshakes, and reports frame completion and overruns.
module frame_scheduler
    import game_timing_pkg::*;
#(
    parameter logic [DIV_W-1:0] BASE_DIV    = BASE_DIV_DEF,
    parameter logic [DIV_W-1:0] STEP_DIV    = STEP_DIV_DEF,
    parameter logic [DIV_W-1:0] MIN_DIV     = MIN_DIV_DEF,
    parameter int unsigned      SPAWN_EVERY = SPAWN_EVERY_DEF
) (
    input  logic                   cin,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic                   pause,
    input  logic [LEVEL_W-1:0]     level,
    frame_scheduler_if.master      eng,
    output logic                   frame_tick,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy,
    output logic                   overrun
);

    localparam int unsigned SPAWN_W = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;

    frame_state_e     state_q;
    frame_state_e     state_d;
    logic             finish_c;
    logic             spawn_due_c;
    logic             tick;
    logic [DIV_W-1:0] period_q;
    logic [SPAWN_W-1:0] spawn_cnt_q;
    logic             move_req_q;
    logic             coll_req_q;
    logic             spawn_req_q;

    rate_prescaler u_prescaler (
        .cin    (cin),
        .rst_n  (rst_n),
        .run    (run),
        .pause  (pause),
        .period (period_q),
        .tick   (tick)
    );

    assign spawn_due_c   = (spawn_cnt_q == SPAWN_W'(SPAWN_EVERY - 1));
    assign eng.move_req  = move_req_q;
    assign eng.coll_req  = coll_req_q;
    assign eng.spawn_req = spawn_req_q;

    // Next-state logic; each done is only looked at in its own phase.
    always_comb begin
        state_d  = state_q;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = MOVE;
                end
            end
            MOVE: begin
                if (eng.move_done) begin
                    state_d = COLL;
                end
            end
            COLL: begin
                if (eng.coll_done) begin
                    if (spawn_due_c) begin
                        state_d = SPAWN;
                    end else begin
                        state_d  = IDLE;
                        finish_c = 1'b1;
                    end
                end
            end
            SPAWN: begin
                if (eng.spawn_done) begin
                    state_d  = IDLE;
                    finish_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; outputs are registered from the next state so they track the state exactly.
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            move_req_q  <= 1'b0;
            coll_req_q  <= 1'b0;
            spawn_req_q <= 1'b0;
            busy        <= 1'b0;
            frame_tick  <= 1'b0;
            frame_count <= '0;
            spawn_cnt_q <= '0;
            overrun     <= 1'b0;
            period_q    <= calc_period('0, BASE_DIV, STEP_DIV, MIN_DIV);
        end else begin
            state_q     <= state_d;
            move_req_q  <= (state_d == MOVE);
            coll_req_q  <= (state_d == COLL);
            spawn_req_q <= (state_d == SPAWN);
            busy        <= (state_d != IDLE);
            frame_tick  <= finish_c;
            if (finish_c) begin
                frame_count <= frame_count + FRAME_CNT_W'(1);
                spawn_cnt_q <= spawn_due_c ? '0 : (spawn_cnt_q + SPAWN_W'(1));
            end
            if (!run) begin
                overrun <= 1'b0;
            end else if (tick && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end
            // Level is sampled on every tick; the new period governs the following interval.
            if (tick) begin
                period_q <= calc_period(level, BASE_DIV, STEP_DIV, MIN_DIV);
            end
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: tick spacing per level, frame
// sequencing, handshake stalls with overrun, pause, async reset and random engine latency.
module tb_frame_scheduler;

    localparam logic [31:0] TB_BASE  = 32'd10;
    localparam logic [31:0] TB_STEP  = 32'd2;
    localparam logic [31:0] TB_MIN   = 32'd4;
    localparam int unsigned TB_SPAWN = 2;

    logic        cin = 1'b0;
    logic        rst_n;
    logic        run;
    logic        pause;
    logic [2:0]  level;
    logic        frame_tick;
    logic [15:0] frame_count;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    frame_scheduler_if eng ();

    frame_scheduler #(
        .BASE_DIV    (TB_BASE),
        .STEP_DIV    (TB_STEP),
        .MIN_DIV     (TB_MIN),
        .SPAWN_EVERY (TB_SPAWN)
    ) dut (
        .cin         (cin),
        .rst_n       (rst_n),
        .run         (run),
        .pause       (pause),
        .level       (level),
        .eng         (eng),
        .frame_tick  (frame_tick),
        .frame_count (frame_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 cin = ~cin;

    // Reference period: plain integer arithmetic from the level rule.
    function automatic int ref_period(input int lv);
        int red;
        red = lv * int'(TB_STEP);
        if (red > int'(TB_BASE)) return int'(TB_MIN);
        if (int'(TB_BASE) - red < int'(TB_MIN)) return int'(TB_MIN);
        return int'(TB_BASE) - red;
    endfunction

    task automatic step();
        @(negedge cin);
        cyc++;
    endtask

    task automatic set_dones(input logic m, input logic c, input logic s);
        eng.move_done  = m;
        eng.coll_done  = c;
        eng.spawn_done = s;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        pause = 1'b0;
        level = 3'd0;
        set_dones(1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_move_rise(input string tag, output int at);
        logic prev;
        prev = eng.move_req;
        at   = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (eng.move_req && !prev) begin
                at = cyc;
                break;
            end
            prev = eng.move_req;
        end
        if (at < 0) begin
            checks++;
            fails++;
            $display("FAIL %s: move_req did not rise within 100 cycles", tag);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        pause = 1'b0;
        level = 3'd0;
        set_dones(1'b0, 1'b0, 1'b0);
        step();
        checks++; if (eng.move_req !== 1'b0)  begin fails++; $display("FAIL reset_move_req: got %b want 0", eng.move_req); end
        checks++; if (eng.coll_req !== 1'b0)  begin fails++; $display("FAIL reset_coll_req: got %b want 0", eng.coll_req); end
        checks++; if (eng.spawn_req !== 1'b0) begin fails++; $display("FAIL reset_spawn_req: got %b want 0", eng.spawn_req); end
        checks++; if (frame_tick !== 1'b0)    begin fails++; $display("FAIL reset_frame_tick: got %b want 0", frame_tick); end
        checks++; if (frame_count !== 16'd0)  begin fails++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        checks++; if (busy !== 1'b0)          begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0)       begin fails++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL idle_no_run_busy: got %b want 0", busy); end
    endtask

    task automatic test_rate();
        int c0, r, r1, r2, r3, lv;
        int lvls[5];
        do_reset();
        set_dones(1'b1, 1'b1, 1'b1);
        level = 3'd0;
        run   = 1'b1;
        c0    = cyc;
        wait_move_rise("rate_first", r);
        checks++; if (r - c0 !== 10) begin fails++; $display("FAIL rate_first_latency: got %0d want 10", r - c0); end
        lvls[0] = 0;
        lvls[1] = 2;
        lvls[2] = 7;
        lvls[3] = int'($urandom_range(0, 7));
        lvls[4] = int'($urandom_range(0, 7));
        foreach (lvls[k]) begin
            lv    = lvls[k];
            level = 3'(lv);
            wait_move_rise("rate_a", r1);
            wait_move_rise("rate_b", r2);
            wait_move_rise("rate_c", r3);
            checks++; if (r2 - r1 !== ref_period(lv)) begin fails++; $display("FAIL rate_spacing1 level %0d: got %0d want %0d", lv, r2 - r1, ref_period(lv)); end
            checks++; if (r3 - r2 !== ref_period(lv)) begin fails++; $display("FAIL rate_spacing2 level %0d: got %0d want %0d", lv, r3 - r2, ref_period(lv)); end
        end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rate_overrun: got %b want 0", overrun); end
        run = 1'b0;
        step();
    endtask

    task automatic test_sequence();
        int  frames, highs, mv;
        bit  spawn_seen, want_spawn;
        logic pm;
        do_reset();
        set_dones(1'b1, 1'b1, 1'b1);
        level = 3'd0;
        run   = 1'b1;
        frames = 0; highs = 0; mv = 0; spawn_seen = 0; pm = 1'b0;
        for (int i = 0; i < 80 && frames < 4; i++) begin
            step();
            if (eng.move_req && !pm) begin
                mv = cyc;
                spawn_seen = 0;
            end
            if (eng.spawn_req) spawn_seen = 1;
            if (frame_tick) begin
                frames++;
                highs++;
                want_spawn = (frames % TB_SPAWN) == 0;
                checks++; if (spawn_seen !== want_spawn) begin fails++; $display("FAIL seq_spawn frame %0d: got %b want %b", frames, spawn_seen, want_spawn); end
                checks++; if (cyc - mv !== (want_spawn ? 3 : 2)) begin fails++; $display("FAIL seq_latency frame %0d: got %0d want %0d", frames, cyc - mv, want_spawn ? 3 : 2); end
                checks++; if (frame_count !== 16'(frames)) begin fails++; $display("FAIL seq_count frame %0d: got %0d want %0d", frames, frame_count, frames); end
            end
            pm = eng.move_req;
        end
        checks++; if (highs !== 4) begin fails++; $display("FAIL seq_pulses: got %0d want 4", highs); end
        checks++; if (frame_count !== 16'd4) begin fails++; $display("FAIL seq_final_count: got %0d want 4", frame_count); end
        run = 1'b0;
        step();
    endtask

    task automatic test_handshake();
        int r;
        do_reset();
        set_dones(1'b0, 1'b1, 1'b1);
        level = 3'd0;
        run   = 1'b1;
        wait_move_rise("hs_start", r);
        for (int i = 0; i < 15; i++) begin
            checks++; if (eng.move_req !== 1'b1 || eng.coll_req !== 1'b0) begin fails++; $display("FAIL hs_hold cycle %0d: move_req %b coll_req %b want 1 0", i, eng.move_req, eng.coll_req); end
            step();
        end
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL hs_overrun_set: got %b want 1", overrun); end
        eng.move_done = 1'b1;
        step();
        checks++; if (eng.coll_req !== 1'b1 || eng.move_req !== 1'b0) begin fails++; $display("FAIL hs_coll_rise: coll_req %b move_req %b want 1 0", eng.coll_req, eng.move_req); end
        step();
        checks++; if (frame_tick !== 1'b1 || frame_count !== 16'd1) begin fails++; $display("FAIL hs_finish: frame_tick %b count %0d want 1 1", frame_tick, frame_count); end
        checks++; if (overrun !== 1'b1) begin fails++; $display("FAIL hs_overrun_sticky: got %b want 1", overrun); end
        run = 1'b0;
        step();
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL hs_overrun_clear: got %b want 0", overrun); end
        step();
    endtask

    task automatic test_pause();
        int r1, r2, off, plen;
        do_reset();
        set_dones(1'b1, 1'b1, 1'b1);
        level = 3'd0;
        run   = 1'b1;
        wait_move_rise("pause_a", r1);
        off  = int'($urandom_range(4, 6));
        plen = int'($urandom_range(1, 6));
        for (int i = 0; i < off; i++) step();
        pause = 1'b1;
        for (int i = 0; i < plen; i++) begin
            step();
            checks++; if ({eng.move_req, eng.coll_req, eng.spawn_req, busy} !== 4'b0) begin fails++; $display("FAIL pause_quiet cycle %0d: reqs/busy %b want 0000", i, {eng.move_req, eng.coll_req, eng.spawn_req, busy}); end
        end
        pause = 1'b0;
        wait_move_rise("pause_b", r2);
        checks++; if (r2 - r1 !== 10 + plen) begin fails++; $display("FAIL pause_stretch: got %0d want %0d", r2 - r1, 10 + plen); end
        run = 1'b0;
        step();
    endtask

    task automatic test_async_reset();
        int c0, r;
        do_reset();
        set_dones(1'b1, 1'b1, 1'b1);
        level = 3'd0;
        run   = 1'b1;
        for (int i = 0; i < 60 && frame_count < 16'd2; i++) step();
        eng.coll_done = 1'b0;
        for (int i = 0; i < 20 && !eng.coll_req; i++) step();
        for (int i = 0; i < 12; i++) step();
        checks++; if (eng.coll_req !== 1'b1 || busy !== 1'b1 || overrun !== 1'b1) begin fails++; $display("FAIL areset_pre: coll_req %b busy %b overrun %b want 1 1 1", eng.coll_req, busy, overrun); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({eng.move_req, eng.coll_req, eng.spawn_req} !== 3'b0) begin fails++; $display("FAIL areset_reqs: got %b want 000", {eng.move_req, eng.coll_req, eng.spawn_req}); end
        checks++; if (frame_tick !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin fails++; $display("FAIL areset_flags: tick %b busy %b overrun %b want 0 0 0", frame_tick, busy, overrun); end
        checks++; if (frame_count !== 16'd0) begin fails++; $display("FAIL areset_count: got %0d want 0", frame_count); end
        step();
        rst_n = 1'b1;
        run   = 1'b0;
        eng.coll_done = 1'b1;
        step();
        run = 1'b1;
        c0  = cyc;
        wait_move_rise("areset_first", r);
        checks++; if (r - c0 !== 10) begin fails++; $display("FAIL areset_first_latency: got %0d want 10", r - c0); end
        run = 1'b0;
        step();
    endtask

    task automatic test_random_frames();
        logic [2:0] req, prev_req, dv;
        int  dly[3];
        int  cnt[3];
        int  frames, mv, exp_len;
        bit  spawn_seen, want_spawn;
        do_reset();
        level = 3'd0;
        run   = 1'b1;
        prev_req = '0; frames = 0; mv = 0; spawn_seen = 0;
        for (int e = 0; e < 3; e++) begin
            dly[e] = 0;
            cnt[e] = 0;
        end
        for (int i = 0; i < 300 && frames < 8; i++) begin
            step();
            req = {eng.spawn_req, eng.coll_req, eng.move_req};
            if (req[0] && !prev_req[0]) begin
                mv = cyc;
                spawn_seen = 0;
            end
            if (req[2]) spawn_seen = 1;
            if (frame_tick) begin
                frames++;
                want_spawn = (frames % TB_SPAWN) == 0;
                exp_len = (dly[0] + 1) + (dly[1] + 1) + (want_spawn ? dly[2] + 1 : 0);
                checks++; if (frame_count !== 16'(frames)) begin fails++; $display("FAIL rnd_count frame %0d: got %0d want %0d", frames, frame_count, frames); end
                checks++; if (spawn_seen !== want_spawn) begin fails++; $display("FAIL rnd_spawn frame %0d: got %b want %b", frames, spawn_seen, want_spawn); end
                checks++; if (cyc - mv !== exp_len) begin fails++; $display("FAIL rnd_frame_len frame %0d: got %0d want %0d", frames, cyc - mv, exp_len); end
            end
            for (int e = 0; e < 3; e++) begin
                if (req[e] && !prev_req[e]) begin
                    dly[e] = int'($urandom_range(0, 2));
                    cnt[e] = 0;
                end
                if (!req[e] && prev_req[e]) begin
                    checks++; if (cnt[e] !== dly[e] + 1) begin fails++; $display("FAIL rnd_phase_len engine %0d: got %0d want %0d", e, cnt[e], dly[e] + 1); end
                end
                if (req[e]) cnt[e]++;
                dv[e] = req[e] ? (cnt[e] - 1 == dly[e]) : 1'($urandom_range(0, 1));
            end
            set_dones(dv[0], dv[1], dv[2]);
            prev_req = req;
        end
        checks++; if (frames !== 8) begin fails++; $display("FAIL rnd_frames: got %0d want 8", frames); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL rnd_overrun: got %b want 0", overrun); end
        run = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_rate();
        test_sequence();
        test_handshake();
        test_pause();
        test_async_reset();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
